// File: rtl/wishbone_initiator.sv
// Single-outstanding pipelined Wishbone initiator.
// A request handshake launches one bus cycle, and the result comes back on a response channel.
// Define WB_INIT_BYTE_MODE_EN to turn on byte-lane steering for requests whose
// sel is exactly 1 (sel[0] set, all other bits clear).
module wishbone_initiator #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_sel,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  input  logic                wb_stall_i
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              init_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [SelW-1:0]   sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CntW-1:0]   cnt_q;

  logic              accept;
  logic              busy;
  logic              ack_take;
  logic              timeout_hit;
  logic [SelW-1:0]   sel_cap;
  logic [DATA_W-1:0] wdata_cap;
  logic [DATA_W-1:0] rdata_ext;

  assign accept   = req_valid && req_ready;
  assign busy     = (state_q == StReq) || (state_q == StWait);
  // An ack only counts once the strobe has been accepted (not stalled).
  assign ack_take = ((state_q == StReq) && !wb_stall_i && wb_ack_i) ||
                    ((state_q == StWait) && wb_ack_i);
  // Ack in the last allowed cycle wins over the timeout.
  assign timeout_hit = busy && !ack_take && (cnt_q == CntW'(TIMEOUT - 1));

`ifdef WB_INIT_BYTE_MODE_EN
  logic              byte_req;
  logic              byte_q;
  logic [DATA_W-1:0] lane_shift;

  assign byte_req   = (req_sel == SelW'(1));
  assign sel_cap    = byte_req ? (SelW'(1) << req_addr[1:0]) : req_sel;
  assign wdata_cap  = byte_req ? (DATA_W'(req_wdata[7:0]) << {req_addr[1:0], 3'b000})
                               : req_wdata;
  assign lane_shift = wb_data_i >> {addr_q[1:0], 3'b000};
  assign rdata_ext  = byte_q ? {{(DATA_W - 8){1'b0}}, lane_shift[7:0]} : wb_data_i;

  // Remember whether the captured request was a byte request, for read-lane extraction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q <= 1'b0;
    end else if (accept) begin
      byte_q <= byte_req;
    end
  end
`else
  assign sel_cap   = req_sel;
  assign wdata_cap = req_wdata;
  assign rdata_ext = wb_data_i;
`endif

  // State register; reset aborts any bus cycle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StReq;
      StReq: begin
        if (ack_take || timeout_hit) begin
          state_d = StResp;
        end else if (!wb_stall_i) begin
          state_d = StWait;
        end
      end
      StWait: if (ack_take || timeout_hit) state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and captured registers.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_sel_o  = '0;
    wb_data_o = '0;
    unique case (state_q)
      StIdle: req_ready = init_q;
      StReq, StWait: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = (state_q == StReq);
        wb_we_o   = we_q;
        wb_addr_o = addr_q;
        wb_sel_o  = sel_q;
        wb_data_o = we_q ? wdata_q : '0;
      end
      StResp: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Request capture and response registers; init_q holds req_ready low until the first clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        sel_q   <= sel_cap;
        wdata_q <= req_we ? wdata_cap : '0;
      end
      if (ack_take) begin
        rdata_q <= we_q ? '0 : rdata_ext;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Cycles spent with cyc high; cleared outside REQ/WAIT and on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (busy && !ack_take && !timeout_hit) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_wishbone_initiator.sv
// Directed bench for wishbone_initiator (32-bit data, 11-bit address, timeout 16).
module tb_wishbone_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [10:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_stall_i;

  int total = 0;
  int bad   = 0;
  int stb_cnt;
  int cyc_cnt;

  wishbone_initiator dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_sel    (req_sel),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_data_o  (wb_data_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request from IDLE; returns in the first REQ cycle.
  task automatic send(input logic [10:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd);
    chk("ready_before_req", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_sel   = sel;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Complete the response handshake and return to IDLE.
  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_drain", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_we     = 1'b0;
    req_sel    = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    wb_data_i  = '0;
    wb_ack_i   = 1'b0;
    wb_stall_i = 1'b0;

    // Reset state
    #2;
    chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_before_first_clk", {63'd0, req_ready}, 64'd0);
    tick();
    chk("ready_after_first_clk", {63'd0, req_ready}, 64'd1);

    // Write 0xCAFEBABE @0x004, ack one cycle after stb
    send(11'h004, 1'b1, 4'hF, 32'hCAFEBABE);
    chk("wr_stb", {63'd0, wb_stb_o}, 64'd1);
    chk("wr_cyc", {63'd0, wb_cyc_o}, 64'd1);
    chk("wr_we", {63'd0, wb_we_o}, 64'd1);
    chk("wr_addr", {53'd0, wb_addr_o}, 64'h004);
    chk("wr_sel", {60'd0, wb_sel_o}, 64'hF);
    chk("wr_data", {32'd0, wb_data_o}, 64'hCAFEBABE);
    chk("wr_ready_busy", {63'd0, req_ready}, 64'd0);
    tick();
    chk("wr_stb_wait", {63'd0, wb_stb_o}, 64'd0);
    chk("wr_cyc_wait", {63'd0, wb_cyc_o}, 64'd1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wr_cyc_resp", {63'd0, wb_cyc_o}, 64'd0);
    chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("wr_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    drain();

    // Read 0xCAFEBABE @0x004 with zero-wait ack; response held while rsp_ready low
    send(11'h004, 1'b0, 4'hF, 32'h12345678);
    chk("rd_data_o_zero", {32'd0, wb_data_o}, 64'd0);
    chk("rd_we", {63'd0, wb_we_o}, 64'd0);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'hCAFEBABE;
    tick();
    wb_data_i = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("rd_rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
      chk("rd_rdata_hold", {32'd0, rsp_rdata}, 64'hCAFEBABE);
      chk("rd_cyc_low", {63'd0, wb_cyc_o}, 64'd0);
      tick();
    end
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
    drain();

    // Stall 3 cycles in REQ: stb high 4 cycles, fields stable
    send(11'h010, 1'b1, 4'h3, 32'h11223344);
    stb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wb_stall_i = (i < 3);
      wb_ack_i   = (i == 5);
      if (rsp_valid) break;
      if (wb_stb_o) begin
        stb_cnt++;
        chk("stall_addr", {53'd0, wb_addr_o}, 64'h010);
        chk("stall_sel", {60'd0, wb_sel_o}, 64'h3);
      end
      tick();
    end
    wb_stall_i = 1'b0;
    wb_ack_i   = 1'b0;
    chk("stall_stb_cycles", stb_cnt, 64'd4);
    chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("stall_rsp_err", {63'd0, rsp_err}, 64'd0);
    drain();
    tick();
    chk("stall_single_rsp", {63'd0, rsp_valid}, 64'd0);

    // No ack: timeout after 16 cycles of cyc
    send(11'h020, 1'b0, 4'hF, 32'h0);
    cyc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_cyc_o) break;
      cyc_cnt++;
      tick();
    end
    chk("to_cyc_cycles", cyc_cnt, 64'd16);
    chk("to_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("to_rsp_err", {63'd0, rsp_err}, 64'd1);
    chk("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    drain();

    // Next request after timeout completes normally
    send(11'h030, 1'b0, 4'hF, 32'h0);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h5A5A0F0F;
    tick();
    wb_ack_i  = 1'b0;
    chk("post_to_rdata", {32'd0, rsp_rdata}, 64'h5A5A0F0F);
    chk("post_to_err", {63'd0, rsp_err}, 64'd0);
    drain();

    // sel=1 request at 0x00B: byte steering when enabled, pass-through otherwise
    send(11'h00B, 1'b1, 4'h1, 32'h000000A5);
`ifdef WB_INIT_BYTE_MODE_EN
    chk("byte_wr_sel", {60'd0, wb_sel_o}, 64'h8);
    chk("byte_wr_data", {32'd0, wb_data_o}, 64'hA5000000);
`else
    chk("byte_wr_sel", {60'd0, wb_sel_o}, 64'h1);
    chk("byte_wr_data", {32'd0, wb_data_o}, 64'h000000A5);
`endif
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    drain();
    send(11'h00B, 1'b0, 4'h1, 32'h0);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'hA5000000;
    tick();
    wb_ack_i  = 1'b0;
    wb_data_i = '0;
`ifdef WB_INIT_BYTE_MODE_EN
    chk("byte_rd_rdata", {32'd0, rsp_rdata}, 64'h000000A5);
`else
    chk("byte_rd_rdata", {32'd0, rsp_rdata}, 64'hA5000000);
`endif
    drain();

    // Reset while in WAIT: bus cycle dropped at once, no response
    send(11'h040, 1'b0, 4'hF, 32'h0);
    tick();
    chk("rst_wait_cyc_before", {63'd0, wb_cyc_o}, 64'd1);
    chk("rst_wait_stb_before", {63'd0, wb_stb_o}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_wait_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_wait_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("rst_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("rst_wait_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_wait_no_rsp", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("rst_wait_no_rsp_late", {63'd0, rsp_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
